// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: state encoding, default widths
// and the operation-length terminal count.
package mul_arbiter_pkg;

  localparam int W_DEF    = 32;
  localparam int CNTW_DEF = 5;
  localparam int TERM_CNT = (1 << CNTW_DEF) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for an n-entry one-hot vector; never zero so N=1 still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after the
// last grant (wrapping) wins; outputs one-hot grant, its index and an any flag.
module rr_pick
  import mul_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  any
);

  localparam int IW = idx_w(N);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between N requesters;
// returns the captured product over a 4-phase req/ack handshake and flags timing faults.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int N    = 2,
  parameter int W    = W_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     u,
  input  logic [N*W-1:0]   x,
  input  logic [N*W-1:0]   y,
  output logic [N-1:0]     ack,
  output logic [2*W-1:0]   z,
  output logic             busy,
  output logic             err,
  output logic             mul_run,
  output logic             mul_u,
  output logic [W-1:0]     mul_x,
  output logic [W-1:0]     mul_y,
  input  logic             mul_stall,
  input  logic [2*W-1:0]   mul_z,
  output logic [1:0]       dbg_state
);

  localparam int IW = idx_w(N);
  localparam logic [CNTW-1:0] TERM = '1;

  // Handshake: requester raises req[i] with x/y/u stable and holds it until
  // ack[i]; z is valid while ack[i] is high; ack falls one cycle after req[i] drops.

  state_e          state, state_nx;
  logic [N-1:0]    g_oh;
  logic [IW-1:0]   rr;
  logic [CNTW-1:0] cnt;
  logic [N-1:0]    pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            last_step, run_exit, req_g;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .last (rr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign last_step = (cnt == TERM);
  // Leaving RUN on a stuck stall at terminal count keeps the requester from hanging.
  assign run_exit  = !mul_stall || last_step;
  assign req_g     = |(req & g_oh);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_any) state_nx = ST_RUN;
      ST_RUN:  if (run_exit) state_nx = ST_DONE;
      ST_DONE: if (!req_g)   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      g_oh <= '0;
      rr   <= IW'(N - 1);
      cnt  <= '0;
      z    <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_any) begin
            g_oh <= pick_gnt;
            rr   <= pick_idx;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNTW'(1);
          if (run_exit) z <= mul_z;
          // Stall must fall exactly on the terminal step; req must stay up.
          if ((mul_stall == last_step) || !req_g) err <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    mul_run   = (state == ST_RUN);
    busy      = (state != ST_IDLE);
    ack       = (state == ST_DONE) ? g_oh : '0;
    dbg_state = state;
    mul_x     = '0;
    mul_y     = '0;
    mul_u     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g_oh[i]) begin
        mul_x = x[i*W +: W];
        mul_y = y[i*W +: W];
        mul_u = u[i];
      end
    end
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Shares one 32-cycle sequential multiplier (run/u/stall/x/y/z interface, 64-bit product) between N requesters, e.g. the RISC core MUL path and a DMA/graphics helper. It picks a requester by round-robin and drives the multiplier's run line for exactly one operation. It captures the 64-bit product and returns it to the granted requester over a 4-phase req/ack handshake. It also checks that the multiplier finishes in the expected cycle count.

Parameters:
N, 2, number of requesters (2..4)
W, 32, operand width; product is 2*W
CNTW, 5, width of operation cycle counter; terminal count = 2**CNTW - 1 = 31

Ports:
CLK  in  1  clock
rst  in  1  asynchronous reset, active low
req  in  N  per-requester request level
u  in  N  per-requester signed flag
x  in  N*W  operands A, requester i at [i*W +: W]
y  in  N*W  operands B, same packing
ack  out  N  one-hot acknowledge; product valid on z while ack[i] high
z  out  2*W  registered product
busy  out  1  high in RUN or DONE
err  out  1  sticky protocol/timing error
mul_run  out  1  to multiplier run
mul_u  out  1  to multiplier u
mul_x  out  W  to multiplier x
mul_y  out  W  to multiplier y
mul_stall  in  1  from multiplier stall
mul_z  in  2*W  from multiplier z

Behaviour:
- Reset (rst=0, async): state=IDLE, ack=0, z=0, busy=0, err=0, mul_run=0, rr pointer=N-1 (requester 0 wins first), cnt=0.
- The multiplier has no reset of its own. mul_run=0 during reset clears its state counter, so at least one CLK edge must occur with rst low.
- States: IDLE, RUN, DONE.
- IDLE: if any req set, grant g = first set bit searching upward from rr+1 (mod N). Register g and go to RUN; rr<=g. mul_run=0 in IDLE.
- RUN: mul_run=1. mul_x/mul_y/mul_u are muxed combinationally from the x/y/u slices of requester g. cnt increments every cycle, starting at 0.
- RUN exit: when mul_stall=0 (multiplier on its last step, cnt==31), load z<=mul_z and go to DONE.
- Timing error: if mul_stall=0 while cnt!=31, or cnt==31 while mul_stall=1, set err (sticky until reset). Then still load z and go to DONE, so a requester is never hung.
- DONE: ack[g]=1, mul_run=0. This forces at least one run-low cycle, so the multiplier restarts at step 0. Return to IDLE when req[g]=0; ack falls in the same transition.
- Requester rules: x, y, u must be held stable while req is high until ack. req must not drop before ack.
- Early req drop: req[g] falling during RUN sets err. The operation still completes, then DONE immediately returns to IDLE on the next cycle.
- Latency: req seen in IDLE at cycle t gives RUN for cycles t+1..t+32, z and ack valid from t+33. Minimum spacing between grants is 34 cycles (33 + one IDLE).
- Simultaneous requests: round-robin strictly alternates. A requester that holds req continuously is served at most once per other waiting requester.
- Requests arriving during RUN/DONE wait, with no loss.
- z holds its value until the next capture. ack is one-hot or zero.
- Async reset mid-RUN: mul_run drops immediately, no ack is issued, and the interrupted requester must re-request.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), W and CNTW defaults, terminal-count constant 31.
- One sub-module is natural: rr_pick (N-bit round-robin priority picker: inputs req and last grant, outputs one-hot grant and index). It is purely combinational and reusable by other arbiters.
- Operand muxing and the FSM stay in mul_arbiter.

Test Plan:
- Single request, unsigned: req0=1, x0=7, y0=6, u0=0 -> mul_run high 32 cycles, ack0 at t+33, z=42, err=0.
- Signed: x0=32'hFFFFFFFD (-3), y0=5, u0=1 -> z=64'hFFFFFFFFFFFFFFF1, ack0 asserted.
- Contention: req0 and req1 rise together with x0=2,y0=3 and x1=4,y1=5 -> requester 0 acked first (z=6). After req0 drops, requester 1 is granted and acked with z=20. Grant starts are 34 cycles apart.
- Fairness: hold req1 high continuously and pulse req0 repeatedly -> grants alternate 0,1,0,1 and no requester waits more than one operation.
- Fault injection: replace the multiplier with a model that drops stall at cnt=20 -> err=1 sticky, ack still issued, arbiter returns to IDLE.
- Reset mid-RUN: assert rst at cnt=10 -> mul_run=0 and ack=0 asynchronously, z=0. After release a fresh req completes in 33 cycles with the correct product.
